// File: rtl/ram_bus_controller.sv
// ram_bus_controller: turns a valid/ready request into a sequenced async RAM cycle.
// It drives the address first, then pulses the active-low strobe, then holds the
// address and data for one more cycle. Read data comes back on a one-cycle pulse.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_write/req_addr/req_wdata sampled at accept
//   rsp_valid/rsp_rdata one-cycle read response, rdata held until the next read
//   addr, rdN, wrN      RAM address and active-low strobes
//   data                shared RAM data bus, driven only for writes
module ram_bus_controller #(
    parameter int SIZE          = 1024,
    parameter int D_WIDTH       = 8,
    parameter int A_WIDTH       = $clog2(SIZE),
    parameter int STROBE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic [A_WIDTH-1:0] addr,
    output logic               rdN,
    output logic               wrN,
    inout  tri   [D_WIDTH-1:0] data
);

    generate
        if (STROBE_CYCLES < 1) begin : g_bad_strobe
            $error("ram_bus_controller: STROBE_CYCLES must be at least 1");
        end
    endgenerate

    // A one-cycle strobe still needs a 1-bit counter to keep widths legal.
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               we;
    logic               oe;
    logic [D_WIDTH-1:0] wdata;
    logic               accept;
    logic               last_strobe;

    assign accept      = req_valid && req_ready;
    assign last_strobe = (cnt == '0);

    // The output enable is set at acceptance so write data is already stable
    // through SETUP, and it is only dropped after HOLD so the RAM write
    // closes on settled data.
    assign data = oe ? wdata : {D_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we        <= 1'b0;
            oe        <= 1'b0;
            wdata     <= '0;
            addr      <= '0;
            rdN       <= 1'b1;
            wrN       <= 1'b1;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr      <= req_addr;
                        we        <= req_write;
                        wdata     <= req_wdata;
                        oe        <= req_write;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Only the strobe for this direction falls; the
                    // other stays high so both can never be low at once.
                    rdN   <= we;
                    wrN   <= ~we;
                    cnt   <= CNT_LOAD;
                    state <= STROBE;
                end
                STROBE: begin
                    if (last_strobe) begin
                        rdN   <= 1'b1;
                        wrN   <= 1'b1;
                        state <= HOLD;
                        // Sample on the edge that ends the strobe, while
                        // the RAM is still driving the bus.
                        if (!we) begin
                            rsp_rdata <= data;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    oe        <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_controller.sv
// tb_ram_bus_controller: directed vectors for ram_bus_controller.
// Three instances with strobe widths 2, 1 and 4, each with a behavioural RAM.
module tb_ram_bus_controller;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       req_valid [N];
    logic       req_ready [N];
    logic       req_write [N];
    logic [9:0] req_addr  [N];
    logic [7:0] req_wdata [N];
    logic       rsp_valid [N];
    logic [7:0] rsp_rdata [N];
    logic [9:0] addr      [N];
    logic       rdN       [N];
    logic       wrN       [N];
    logic [7:0] bus_obs   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int SC = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        wire  [7:0] bus;
        logic [7:0] mem [1024];

        // Released bus reads as all ones.
        for (genvar k = 0; k < 8; k++) begin : g_pu
            pullup pu (bus[k]);
        end

        assign bus = !rdN[g] ? mem[addr[g]] : 8'bz;
        assign bus_obs[g] = bus;

        always @(posedge clk) begin
            if (!wrN[g]) mem[addr[g]] <= bus;
        end

        ram_bus_controller #(
            .SIZE(1024),
            .D_WIDTH(8),
            .STROBE_CYCLES(SC)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .addr(addr[g]),
            .rdN(rdN[g]),
            .wrN(wrN[g]),
            .data(bus)
        );
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int inv_bad = 0;
    logic mon_en = 1'b0;
    logic       p_low  [N];
    logic [9:0] p_addr [N];

    logic       bw [4];
    logic [9:0] ba [4];
    logic [7:0] bd [4];

    function automatic int sc_of(input int u);
        return (u == 0) ? 2 : (u == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bus-level invariants, sampled mid-cycle on every instance.
    always @(negedge clk) begin
        for (int u = 0; u < N; u++) begin
            if (mon_en) begin
                if (!rdN[u] && !wrN[u])
                    inv_bad <= inv_bad + 1;
                if ((!rdN[u] || !wrN[u]) && p_low[u] && addr[u] != p_addr[u])
                    inv_bad <= inv_bad + 1;
                if (req_ready[u] && bus_obs[u] != 8'hFF)
                    inv_bad <= inv_bad + 1;
            end
            p_low[u]  <= !rdN[u] || !wrN[u];
            p_addr[u] <= addr[u];
        end
    end

    task automatic run_txn(input int u, input logic we, input logic [9:0] a,
                           input logic [7:0] wd, input logic scr,
                           output logic [7:0] rd, output int slow,
                           output int soth, output int nrsp,
                           output int busy, output int bad);
        int n;
        req_valid[u] = 1'b1;
        req_write[u] = we;
        req_addr[u]  = a;
        req_wdata[u] = wd;
        n = 0;
        while (!req_ready[u] && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait_tmo", n >= 20, 0);
        tick();
        req_valid[u] = 1'b0;
        if (scr) begin
            req_write[u] = ~we;
            req_addr[u]  = ~a;
            req_wdata[u] = ~wd;
        end
        rd = 8'h00;
        slow = 0; soth = 0; nrsp = 0; busy = 0; bad = 0;
        n = 0;
        while (!req_ready[u] && n < 20) begin
            if (we ? !wrN[u] : !rdN[u]) slow++;
            if (we ? !rdN[u] : !wrN[u]) soth++;
            if (rsp_valid[u]) begin
                nrsp++;
                rd = rsp_rdata[u];
            end
            if (we && bus_obs[u] != wd) bad++;
            if (!we && rdN[u] && bus_obs[u] != 8'hFF) bad++;
            busy++;
            tick();
            n++;
        end
        if (rsp_valid[u]) nrsp++;
        if (bus_obs[u] != 8'hFF) bad++;
    endtask

    task automatic txn(input int u, input logic we, input logic [9:0] a,
                       input logic [7:0] d, input logic scr, input string tag);
        logic [7:0] rd;
        int slow, soth, nrsp, busy, bad;
        run_txn(u, we, a, d, scr, rd, slow, soth, nrsp, busy, bad);
        chk({tag, "_strobe_w"}, slow, sc_of(u));
        chk({tag, "_other_strobe"}, soth, 0);
        chk({tag, "_busy"}, busy, sc_of(u) + 2);
        chk({tag, "_rsp_cnt"}, nrsp, we ? 0 : 1);
        chk({tag, "_bus"}, bad, 0);
        if (!we) chk({tag, "_rdata"}, rd, d);
    endtask

    // Back-to-back requests with req_valid held; for reads bd holds the
    // expected data. The next request is presented during SETUP.
    task automatic burst(input int u, input int n, input string tag);
        int t, acc, prev, seen;
        logic [7:0] r;
        prev = 0;
        req_valid[u] = 1'b1;
        req_write[u] = bw[0];
        req_addr[u]  = ba[0];
        req_wdata[u] = bd[0];
        t = 0;
        while (!req_ready[u] && t < 20) begin
            tick();
            t++;
        end
        for (int k = 0; k < n; k++) begin
            tick();
            acc = cyc;
            if (k > 0) chk({tag, "_gap"}, acc - prev, sc_of(u) + 3);
            prev = acc;
            if (k + 1 < n) begin
                req_write[u] = bw[k+1];
                req_addr[u]  = ba[k+1];
                req_wdata[u] = bd[k+1];
            end else begin
                req_valid[u] = 1'b0;
            end
            seen = 0;
            r = 8'h00;
            t = 0;
            while (!req_ready[u] && t < 20) begin
                if (rsp_valid[u]) begin
                    seen++;
                    r = rsp_rdata[u];
                end
                tick();
                t++;
            end
            chk({tag, "_done_tmo"}, t >= 20, 0);
            chk({tag, "_rsp_cnt"}, seen, bw[k] ? 0 : 1);
            if (!bw[k]) chk({tag, "_rdata"}, r, bd[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        for (int u = 0; u < N; u++) begin
            req_valid[u] = 1'b1;
            req_write[u] = 1'b1;
            req_addr[u]  = 10'h155;
            req_wdata[u] = 8'h3A;
        end
        tick();
        tick();
        for (int u = 0; u < N; u++) begin
            chk("rst_ready", req_ready[u], 1);
            chk("rst_addr", addr[u], 0);
        end
        chk("rst_rdN", rdN[0], 1);
        chk("rst_wrN", wrN[0], 1);
        chk("rst_bus", bus_obs[0], 8'hFF);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_rdata", rsp_rdata[0], 0);
        for (int u = 0; u < N; u++) req_valid[u] = 1'b0;
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("idle_ready", req_ready[0], 1);

        txn(0, 1'b1, 10'h123, 8'hA5, 1'b0, "wr123");
        txn(0, 1'b0, 10'h123, 8'hA5, 1'b0, "rd123");

        txn(0, 1'b1, 10'h3FF, 8'h3C, 1'b0, "wr3ff");
        txn(0, 1'b1, 10'h3FE, 8'hC3, 1'b0, "wr3fe");
        bw = '{1'b1, 1'b0, 1'b1, 1'b0};
        ba = '{10'h000, 10'h3FF, 10'h001, 10'h3FE};
        bd = '{8'h11, 8'h3C, 8'h22, 8'hC3};
        burst(0, 4, "b2b");
        txn(0, 1'b0, 10'h000, 8'h11, 1'b1, "rd000");
        txn(0, 1'b0, 10'h001, 8'h22, 1'b1, "rd001");

        txn(0, 1'b1, 10'h055, 8'h66, 1'b1, "scr_wr");
        txn(0, 1'b0, 10'h055, 8'h66, 1'b0, "scr_rd");

        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 10'h0AB;
        req_wdata[0] = 8'h99;
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("abort_wr_low", wrN[0], 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wrN", wrN[0], 1);
        chk("abort_bus", bus_obs[0], 8'hFF);
        chk("abort_ready", req_ready[0], 1);
        chk("abort_rsp", rsp_valid[0], 0);

        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 10'h123;
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("abort_rd_low", rdN[0], 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rdN", rdN[0], 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[0]) seen++;
            tick();
        end
        chk("abort_rd_no_rsp", seen, 0);

        txn(1, 1'b1, 10'h200, 8'h5C, 1'b0, "sc1_wr");
        txn(1, 1'b0, 10'h200, 8'h5C, 1'b0, "sc1_rd");
        bw[0] = 1'b1; ba[0] = 10'h010; bd[0] = 8'h77;
        bw[1] = 1'b0; ba[1] = 10'h200; bd[1] = 8'h5C;
        burst(1, 2, "sc1_b2b");
        txn(1, 1'b0, 10'h010, 8'h77, 1'b0, "sc1_rd2");

        txn(2, 1'b1, 10'h2AA, 8'h4D, 1'b0, "sc4_wr");
        txn(2, 1'b0, 10'h2AA, 8'h4D, 1'b0, "sc4_rd");
        bw[0] = 1'b1; ba[0] = 10'h3FF; bd[0] = 8'h0F;
        bw[1] = 1'b0; ba[1] = 10'h2AA; bd[1] = 8'h4D;
        burst(2, 2, "sc4_b2b");
        txn(2, 1'b0, 10'h3FF, 8'h0F, 1'b0, "sc4_rd2");

        tick();
        chk("invariants", inv_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bus_controller.md
# ram_bus_controller

Synchronous initiator for the asynchronous, strobe-driven RAM bus (`addr`, `rdN`, `wrN`, shared tri-state `data`). It converts a single-clock valid/ready request interface into correctly sequenced RAM cycles, in the order address setup, active-low strobe, then hold. For reads it captures read data and returns it on a one-cycle response pulse. It sits between core logic and one parameterized RAM instance and owns the bus direction.

## Interface

Parameters:

- `SIZE`, 1024: RAM depth in words.
- `D_WIDTH`, 8: data bus width.
- `A_WIDTH`, `$clog2(SIZE)`: address width.
- `STROBE_CYCLES`, 2: number of clocks `rdN`/`wrN` are held low. Legal range is ≥1; values <1 are an elaboration error.

Ports:

- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: the controller is idle and accepts a request this cycle.
- `req_write` input 1: 1 = write, 0 = read. Sampled at acceptance only.
- `req_addr` input `A_WIDTH`: word address, sampled at acceptance.
- `req_wdata` input `D_WIDTH`: write data, sampled at acceptance.
- `rsp_valid` output 1: one-cycle pulse carrying read data. No backpressure.
- `rsp_rdata` output `D_WIDTH`: captured read data, held until the next read capture.
- `addr` output `A_WIDTH`: RAM address.
- `rdN` output 1: RAM read strobe, active-low.
- `wrN` output 1: RAM write strobe, active-low.
- `data` inout tri `D_WIDTH`: RAM data bus. Driven only during write cycles, `'z` otherwise.

## Operation

States are `IDLE`, `SETUP`, `STROBE`, `HOLD`. All outputs are registered.

- **IDLE:** `req_ready`=1 and strobes are high. On `req_valid && req_ready`:
  - Latch address, write flag and write data.
  - `addr` takes the request address.
  - Set the bus output enable if the request is a write.
  - Go to `SETUP`.
- **SETUP:** exactly 1 cycle. `addr` and (for writes) `data` are stable, strobes are high. Next state is `STROBE`; the selected strobe goes low and the counter loads `STROBE_CYCLES-1`.
- **STROBE:** lasts `STROBE_CYCLES` cycles.
  - The counter decrements each cycle.
  - On the edge ending the last strobe cycle:
    - The strobe returns high.
    - For a read, `rsp_rdata` is loaded from `data` and `rsp_valid` is set to 1.
    - State goes to `HOLD`.
- **HOLD:** exactly 1 cycle.
  - `addr` and write data remain driven while strobes are high, so the level-sensitive RAM write settles on stable data.
  - `rsp_valid`=1 during this cycle for reads.
  - Next edge: output enable goes to 0, `rsp_valid` to 0, `req_ready` to 1, state to `IDLE`.

Invariants:

- `rdN` and `wrN` are never low simultaneously.
- `data` is never driven while `rdN` is low.
- `data` is never driven in `IDLE`.
- `addr` does not change while either strobe is low.
- `addr` holds its last value in `IDLE`.

Reset values:

- State `IDLE`.
- `req_ready`=1, `rdN`=1, `wrN`=1.
- `data`=`'z` (output enable 0).
- `addr`=0.
- `rsp_valid`=0, `rsp_rdata`=0.
- Counter 0.

Boundary conditions:

- **Reset mid-operation:** on the reset edge, strobes return high and the bus is released in the same edge. No response is issued for the aborted transaction. A partial write may have occurred in the RAM.
- **Request arriving while busy:** `req_ready`=0, so the request is not accepted. The requester must hold it; no state changes.
- **`req_*` changing after acceptance:** ignored.
- **`STROBE_CYCLES`=1:** the strobe is low for exactly one cycle.
- **Address wrap:** `addr` is passed through unmodified. Out-of-range addresses (when `SIZE` is not a power of 2) are the requester's responsibility.

## Timing

- Acceptance edge is E0. The request occupies E0 to E0+`STROBE_CYCLES`+3; `req_ready` is low for `STROBE_CYCLES`+2 cycles.
- Strobe falls at E0+1 and rises at E0+1+`STROBE_CYCLES`.
- Read data is sampled at E0+1+`STROBE_CYCLES`, while `rdN` is still low in the cycle before.
- `rsp_valid` is high from E0+1+`STROBE_CYCLES` to E0+2+`STROBE_CYCLES` (one cycle).
- Bus released and `req_ready`=1 at E0+2+`STROBE_CYCLES`.
- The earliest next acceptance is that edge's following edge.
- Throughput: 1 transaction per `STROBE_CYCLES`+3 clocks (5 at default).

## Test plan

- **Reset:** assert `rst` for 2 cycles with `req_valid`=1.
  - Expect `req_ready`=1, `rdN`=`wrN`=1, `data`=z, `addr`=0, `rsp_valid`=0.
  - No acceptance while `rst`=1.
- **Write then read:** write 0xA5 to address 0x123 (default parameters).
  - Expect `wrN` low for exactly 2 cycles, `data`=0xA5 from SETUP through HOLD, `data`=z afterwards.
  - Then read 0x123: `rdN` low for 2 cycles, `rsp_valid` pulses once with `rsp_rdata`=0xA5, and `data` is never driven by the controller.
- **Back-to-back traffic:** hold `req_valid`=1 for 4 alternating write/read requests to addresses 0, 0x3FF, 1, 0x3FE.
  - Acceptances exactly 5 cycles apart.
  - Reads return the previously written values.
  - Strobes never overlap and `addr` never changes while a strobe is low.
- **Reset mid-operation:** assert `rst` during the second STROBE cycle of a write.
  - `wrN`=1 and `data`=z after the reset edge, no `rsp_valid`, `req_ready`=1.
- **Strobe length variant:** `STROBE_CYCLES`=1 and then 4.
  - Strobe widths are 1 and 4 cycles.
  - Transaction periods are 4 and 7 cycles.
  - Read data is correct in both cases.
- **Request input changes after acceptance:** change `req_addr`, `req_write` and `req_wdata` during SETUP.
  - The transaction uses the values sampled at acceptance.
